// File: rtl/pwm_ramp_pkg.sv
// Shared types and constants for the PWM on-time soft-start/soft-stop ramp controller.
package pwm_ramp_pkg;

  localparam int DEFAULT_WIDTH       = 32;
  localparam int DEFAULT_DWELL_WIDTH = 16;
  localparam int DWELL_MIN           = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

endpackage : pwm_ramp_pkg

// File: rtl/pwm_ramp_controller_if.sv
// Ramp command bus from the register file: a single-cycle strobe plus target/step/dwell.
interface pwm_ramp_controller_if
  import pwm_ramp_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DWELL_WIDTH = DEFAULT_DWELL_WIDTH
);

  logic                   cmd_valid;
  logic [WIDTH-1:0]       cmd_target;
  logic [WIDTH-1:0]       cmd_step;
  logic [DWELL_WIDTH-1:0] cmd_dwell;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_step,
    output cmd_dwell
  );

  modport slave (
    input cmd_valid,
    input cmd_target,
    input cmd_step,
    input cmd_dwell
  );

endinterface : pwm_ramp_controller_if

// File: rtl/pwm_ramp_step.sv
// Combinational saturating next-on-time calculator: moves current toward target by step,
// never overshooting, wrapping or underflowing.
module pwm_ramp_step
  import pwm_ramp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] current,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] next,
  output logic             reached
);

  logic [WIDTH:0]   sum_up;
  logic [WIDTH-1:0] diff_down;

  always_comb begin
    sum_up    = {1'b0, current} + {1'b0, step};
    diff_down = current - target;
    next      = target;

    if (step == '0) begin
      next = target;
    end else if (current < target) begin
      // The extra carry bit lets a huge step saturate at target instead of wrapping.
      if (sum_up >= {1'b0, target}) begin
        next = target;
      end else begin
        next = sum_up[WIDTH-1:0];
      end
    end else if (current > target) begin
      if (diff_down <= step) begin
        next = target;
      end else begin
        next = current - step;
      end
    end else begin
      next = target;
    end
  end

  assign reached = (next == target);

endmodule : pwm_ramp_step

// File: rtl/pwm_ramp_controller.sv
// Soft-start/soft-stop sequencer: steps one PWM channel's on-time toward a target,
// one step every N period reloads, so the channel always latches a coherent value.
module pwm_ramp_controller
  import pwm_ramp_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DWELL_WIDTH = DEFAULT_DWELL_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  pwm_ramp_controller_if.slave cmd,
  input  logic [WIDTH-1:0]     period_limit,
  input  logic                 period_tick,
  input  logic                 abort,
  output logic [WIDTH-1:0]     on_time,
  output logic                 on_time_update,
  output logic                 busy,
  output logic                 at_target
);

  ramp_state_e            state_q, state_d;
  logic [WIDTH-1:0]       on_time_q, on_time_d;
  logic [WIDTH-1:0]       target_q, target_d;
  logic [WIDTH-1:0]       step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic                   update_q, update_d;

  logic [WIDTH-1:0]       clamped_target;
  logic [DWELL_WIDTH-1:0] cmd_dwell_eff;
  logic [WIDTH-1:0]       step_next;
  logic                   step_reached;

  pwm_ramp_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .current (on_time_q),
    .target  (target_q),
    .step    (step_q),
    .next    (step_next),
    .reached (step_reached)
  );

  assign clamped_target = (cmd.cmd_target > period_limit) ? period_limit : cmd.cmd_target;
  assign cmd_dwell_eff  = (cmd.cmd_dwell == '0) ? DWELL_WIDTH'(DWELL_MIN) : cmd.cmd_dwell;

  always_comb begin
    state_d     = state_q;
    on_time_d   = on_time_q;
    target_d    = target_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    update_d    = 1'b0;

    // abort outranks everything, including a disabled controller and a same-cycle command.
    if (abort) begin
      on_time_d = '0;
      target_d  = '0;
      state_d   = IDLE;
      update_d  = (on_time_q != '0);
    end else if (enable) begin
      if (cmd.cmd_valid) begin
        target_d    = clamped_target;
        step_d      = cmd.cmd_step;
        dwell_d     = cmd_dwell_eff;
        dwell_cnt_d = cmd_dwell_eff;
        state_d     = (clamped_target != on_time_q) ? RAMP : IDLE;
      end else if ((state_q == RAMP) && period_tick) begin
        if (dwell_cnt_q <= DWELL_WIDTH'(DWELL_MIN)) begin
          on_time_d   = step_next;
          update_d    = (step_next != on_time_q);
          dwell_cnt_d = dwell_q;
          if (step_reached) begin
            state_d = IDLE;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      on_time_q   <= '0;
      target_q    <= '0;
      step_q      <= '0;
      dwell_q     <= DWELL_WIDTH'(DWELL_MIN);
      dwell_cnt_q <= '0;
      update_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      on_time_q   <= on_time_d;
      target_q    <= target_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      update_q    <= update_d;
    end
  end

  assign on_time        = on_time_q;
  assign on_time_update = update_q;
  assign busy           = (state_q == RAMP);
  assign at_target      = (state_q == IDLE) && (on_time_q == target_q);

endmodule : pwm_ramp_controller

// File: tb/tb_pwm_ramp_controller.sv
// Directed-vector bench for pwm_ramp_controller with hand-computed expected on-time sequences.
module tb_pwm_ramp_controller;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] period_limit;
  logic        period_tick;
  logic        abort;
  logic [31:0] on_time;
  logic        on_time_update;
  logic        busy;
  logic        at_target;

  int vector_count = 0;
  int miss_count   = 0;

  pwm_ramp_controller_if #(.WIDTH(32), .DWELL_WIDTH(16)) cmd_if ();

  pwm_ramp_controller #(
    .WIDTH(32),
    .DWELL_WIDTH(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .cmd            (cmd_if),
    .period_limit   (period_limit),
    .period_tick    (period_tick),
    .abort          (abort),
    .on_time        (on_time),
    .on_time_update (on_time_update),
    .busy           (busy),
    .at_target      (at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic doCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of strobes, then clears them; outputs are observed #1 after the edge.
  task automatic applyStimulus(input logic tick, input logic cmd, input logic [31:0] tgt,
                               input logic [31:0] stp, input logic [15:0] dw, input logic ab);
    period_tick       = tick;
    cmd_if.cmd_valid  = cmd;
    cmd_if.cmd_target = tgt;
    cmd_if.cmd_step   = stp;
    cmd_if.cmd_dwell  = dw;
    abort             = ab;
    doCycle();
    period_tick      = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    abort            = 1'b0;
  endtask

  task automatic expectState(input string tag, input logic [31:0] exp_on, input logic exp_upd,
                             input logic exp_busy, input logic exp_at);
    checkOutput({tag, ".on_time"}, on_time, exp_on);
    checkOutput({tag, ".update"}, {31'd0, on_time_update}, {31'd0, exp_upd});
    checkOutput({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
    checkOutput({tag, ".at_target"}, {31'd0, at_target}, {31'd0, exp_at});
  endtask

  task automatic sendCmd(input string tag, input logic [31:0] tgt, input logic [31:0] stp,
                         input logic [15:0] dw, input logic [31:0] exp_on, input logic exp_busy);
    applyStimulus(1'b0, 1'b1, tgt, stp, dw, 1'b0);
    expectState(tag, exp_on, 1'b0, exp_busy, !exp_busy);
  endtask

  // One tick, then idle gap; the strobe must be gone one cycle after it appeared.
  task automatic tickExpect(input string tag, input logic [31:0] exp_on, input logic exp_upd,
                            input logic exp_busy, input logic exp_at);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
    expectState(tag, exp_on, exp_upd, exp_busy, exp_at);
    doCycle();
    checkOutput({tag, ".strobe_off"}, {31'd0, on_time_update}, 32'd0);
    doCycle();
    doCycle();
  endtask

  initial begin
    reset             = 1'b1;
    enable            = 1'b1;
    period_limit      = 32'd1000;
    period_tick       = 1'b0;
    abort             = 1'b0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_target = '0;
    cmd_if.cmd_step   = '0;
    cmd_if.cmd_dwell  = '0;
    doCycle();
    doCycle();
    expectState("reset", 32'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    doCycle();

    // Ramp up: 100 in steps of 30, one step per two ticks
    sendCmd("up.cmd", 32'd100, 32'd30, 16'd2, 32'd0, 1'b1);
    tickExpect("up.t1", 32'd0,   1'b0, 1'b1, 1'b0);
    tickExpect("up.t2", 32'd30,  1'b1, 1'b1, 1'b0);
    tickExpect("up.t3", 32'd30,  1'b0, 1'b1, 1'b0);
    tickExpect("up.t4", 32'd60,  1'b1, 1'b1, 1'b0);
    tickExpect("up.t5", 32'd60,  1'b0, 1'b1, 1'b0);
    tickExpect("up.t6", 32'd90,  1'b1, 1'b1, 1'b0);
    tickExpect("up.t7", 32'd90,  1'b0, 1'b1, 1'b0);
    tickExpect("up.t8", 32'd100, 1'b1, 1'b0, 1'b1);

    // Clamp to period_limit with step 0, then ramp down with no underflow
    period_limit = 32'd400;
    sendCmd("clamp.cmd", 32'd5000, 32'd0, 16'd1, 32'd100, 1'b1);
    tickExpect("clamp.t1", 32'd400, 1'b1, 1'b0, 1'b1);
    sendCmd("down.cmd", 32'd0, 32'd150, 16'd1, 32'd400, 1'b1);
    tickExpect("down.t1", 32'd250, 1'b1, 1'b1, 1'b0);
    tickExpect("down.t2", 32'd100, 1'b1, 1'b1, 1'b0);
    tickExpect("down.t3", 32'd0,   1'b1, 1'b0, 1'b1);

    // Command and tick together: command wins, dwell restarts at 2
    period_limit = 32'd1000;
    sendCmd("sim.cmd", 32'd100, 32'd30, 16'd1, 32'd0, 1'b1);
    tickExpect("sim.t1", 32'd30, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'd100, 32'd30, 16'd2, 1'b0);
    expectState("sim.cmdtick", 32'd30, 1'b0, 1'b1, 1'b0);
    tickExpect("sim.t2", 32'd30, 1'b0, 1'b1, 1'b0);
    tickExpect("sim.t3", 32'd60, 1'b1, 1'b1, 1'b0);

    // Abort with a command in the same cycle: command discarded
    applyStimulus(1'b0, 1'b1, 32'd500, 32'd10, 16'd1, 1'b1);
    expectState("abort.cmd", 32'd0, 1'b1, 1'b0, 1'b1);
    tickExpect("abort.t1", 32'd0, 1'b0, 1'b0, 1'b1);

    // Freeze at 60 across five ticks, then resume
    sendCmd("frz.cmd", 32'd100, 32'd30, 16'd1, 32'd0, 1'b1);
    tickExpect("frz.t1", 32'd30, 1'b1, 1'b1, 1'b0);
    tickExpect("frz.t2", 32'd60, 1'b1, 1'b1, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tickExpect("frz.hold", 32'd60, 1'b0, 1'b1, 1'b0);
    end
    enable = 1'b1;
    tickExpect("frz.t3", 32'd90,  1'b1, 1'b1, 1'b0);
    tickExpect("frz.t4", 32'd100, 1'b1, 1'b0, 1'b1);

    // Retarget from 200 to 50 while at 120
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    expectState("rt.abort", 32'd0, 1'b1, 1'b0, 1'b1);
    sendCmd("rt.cmd", 32'd200, 32'd40, 16'd1, 32'd0, 1'b1);
    tickExpect("rt.t1", 32'd40,  1'b1, 1'b1, 1'b0);
    tickExpect("rt.t2", 32'd80,  1'b1, 1'b1, 1'b0);
    tickExpect("rt.t3", 32'd120, 1'b1, 1'b1, 1'b0);
    sendCmd("rt.retarget", 32'd50, 32'd40, 16'd1, 32'd120, 1'b1);
    tickExpect("rt.t4", 32'd80, 1'b1, 1'b1, 1'b0);
    tickExpect("rt.t5", 32'd50, 1'b1, 1'b0, 1'b1);

    // Reset mid-ramp
    sendCmd("rst.cmd", 32'd200, 32'd40, 16'd1, 32'd50, 1'b1);
    tickExpect("rst.t1", 32'd90, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    doCycle();
    expectState("rst.mid", 32'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    doCycle();

    // dwell 0 behaves as 1; target equal to on_time does not ramp
    sendCmd("dw0.cmd", 32'd60, 32'd30, 16'd0, 32'd0, 1'b1);
    tickExpect("dw0.t1", 32'd30, 1'b1, 1'b1, 1'b0);
    tickExpect("dw0.t2", 32'd60, 1'b1, 1'b0, 1'b1);
    sendCmd("same.cmd", 32'd60, 32'd10, 16'd1, 32'd60, 1'b0);
    tickExpect("same.t1", 32'd60, 1'b0, 1'b0, 1'b1);

    // Near-full-scale target with huge step saturates, no wrap
    period_limit = 32'hFFFF_FFFF;
    sendCmd("sat.cmd", 32'hFFFF_FFF0, 32'hFFFF_0000, 16'd1, 32'd60, 1'b1);
    tickExpect("sat.t1", 32'hFFFF_003C, 1'b1, 1'b1, 1'b0);
    tickExpect("sat.t2", 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b1);
    sendCmd("satdn.cmd", 32'd10, 32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFF0, 1'b1);
    tickExpect("satdn.t1", 32'd10, 1'b1, 1'b0, 1'b1);

    // Lowering the limit in IDLE changes nothing
    period_limit = 32'd5;
    tickExpect("lim.t1", 32'd10, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule : tb_pwm_ramp_controller
